// File: rtl/ttc_synchro_p.sv
// ttc_synchro_p
// -----------------------------------------------------------------------------
// TTC/CCB command synchroniser. It decodes strobed CCB commands and keeps the
// bunch-crossing (BXN) counter and the orbit counter. It also runs the FMM
// trigger-enable state machine and checks BC0 alignment, keeping a saturating
// count of misaligned BC0s.
//
// Ports
//   clk               system clock; all state changes on the rising edge
//   hard_rst          synchronous active-high reset
//   ccb_cmd           CCB command code
//   ccb_cmd_strobe    command valid, one cycle per command
//   bxn_offset        value loaded into the BXN counter on BC0 / L1Reset
//   lhc_cycle_sel     orbit length select (1 = LEN_LONG, 0 = LEN_SHORT)
//   ttc_bc0 .. ttc_oc0  combinational command decodes (strobe-qualified)
//   bxn_counter       current bunch-crossing number, 0..len-1
//   bxn_before_reset  BXN value captured on the last BC0
//   orbit_counter     number of BC0s since the last OC0 or reset
//   l1a_cnt_reset     one-cycle pulse to clear the L1A counters
//   fmm_trig_stop     1 = triggers inhibited
//   fmm_state         FSM state code (0 STOPPED, 1 L1RST, 2 WAIT_BC0, 3 RUNNING)
//   bc0_err           one-cycle pulse on a misaligned BC0
//   bc0_err_cnt       saturating count of misaligned BC0s
//   bc0_locked        set once a BC0 has been seen since reset / L1Reset
// -----------------------------------------------------------------------------
module ttc_synchro_p #(
  parameter int BXN_W       = 12,
  parameter int ORB_W       = 16,
  parameter int CMD_W       = 6,
  parameter int LEN_LONG    = 3564,
  parameter int LEN_SHORT   = 924,
  parameter int CMD_BC0     = 1,
  parameter int CMD_L1RESET = 3,
  parameter int CMD_START   = 6,
  parameter int CMD_STOP    = 7,
  parameter int CMD_OC0     = 8,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic [CMD_W-1:0] ccb_cmd,
  input  logic             ccb_cmd_strobe,
  input  logic [BXN_W-1:0] bxn_offset,
  input  logic             lhc_cycle_sel,
  output logic             ttc_bc0,
  output logic             ttc_l1reset,
  output logic             ttc_start_trigger,
  output logic             ttc_stop_trigger,
  output logic             ttc_oc0,
  output logic [BXN_W-1:0] bxn_counter,
  output logic [BXN_W-1:0] bxn_before_reset,
  output logic [ORB_W-1:0] orbit_counter,
  output logic             l1a_cnt_reset,
  output logic             fmm_trig_stop,
  output logic [1:0]       fmm_state,
  output logic             bc0_err,
  output logic [ERR_W-1:0] bc0_err_cnt,
  output logic             bc0_locked
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_L1RST    = 2'd1,
    ST_WAIT_BC0 = 2'd2,
    ST_RUNNING  = 2'd3
  } fmm_state_e;

  fmm_state_e state_q;
  fmm_state_e state_next;

  // ---------------------------------------------------------------------------
  // Command decode: zero latency, only one code can match per strobe
  // ---------------------------------------------------------------------------
  assign ttc_bc0           = ccb_cmd_strobe && (ccb_cmd == CMD_W'(CMD_BC0));
  assign ttc_l1reset       = ccb_cmd_strobe && (ccb_cmd == CMD_W'(CMD_L1RESET));
  assign ttc_start_trigger = ccb_cmd_strobe && (ccb_cmd == CMD_W'(CMD_START));
  assign ttc_stop_trigger  = ccb_cmd_strobe && (ccb_cmd == CMD_W'(CMD_STOP));
  assign ttc_oc0           = ccb_cmd_strobe && (ccb_cmd == CMD_W'(CMD_OC0));

  // ---------------------------------------------------------------------------
  // Orbit geometry
  // ---------------------------------------------------------------------------
  logic [BXN_W-1:0] len;
  logic [BXN_W-1:0] len_m1;
  logic [BXN_W-1:0] off_eff;
  logic [BXN_W-1:0] bc0_expected;
  logic             bc0_misaligned;

  assign len     = lhc_cycle_sel ? BXN_W'(LEN_LONG) : BXN_W'(LEN_SHORT);
  assign len_m1  = len - BXN_W'(1);
  // An offset outside the current orbit would park the counter out of range.
  assign off_eff = (bxn_offset < len) ? bxn_offset : '0;

  // A BC0 is aligned when it lands on the last BX before the reload value.
  assign bc0_expected   = (off_eff == '0) ? len_m1 : (off_eff - BXN_W'(1));
  assign bc0_misaligned = ttc_bc0 && bc0_locked && (bxn_counter != bc0_expected);

  // ---------------------------------------------------------------------------
  // FMM state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (ttc_l1reset)            state_next = ST_L1RST;
        else if (ttc_start_trigger) state_next = ST_WAIT_BC0;
      end
      ST_L1RST: begin
        state_next = ST_WAIT_BC0;
      end
      ST_WAIT_BC0: begin
        if (ttc_bc0)               state_next = ST_RUNNING;
        else if (ttc_l1reset)      state_next = ST_L1RST;
        else if (ttc_stop_trigger) state_next = ST_STOPPED;
      end
      ST_RUNNING: begin
        if (ttc_stop_trigger) state_next = ST_STOPPED;
        else if (ttc_l1reset) state_next = ST_L1RST;
      end
      default: state_next = ST_STOPPED;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q       <= ST_STOPPED;
      fmm_trig_stop <= 1'b1;
      l1a_cnt_reset <= 1'b1;
    end else begin
      state_q       <= state_next;
      fmm_trig_stop <= (state_next != ST_RUNNING);
      // Registered from state_next so the pulse coincides with the L1RST cycle.
      l1a_cnt_reset <= (state_next == ST_L1RST);
    end
  end

  assign fmm_state = state_q;

  // ---------------------------------------------------------------------------
  // BXN counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      bxn_counter      <= off_eff;
      bxn_before_reset <= '0;
    end else if (ttc_bc0) begin
      bxn_before_reset <= bxn_counter;
      bxn_counter      <= off_eff;
    end else if (state_q == ST_L1RST) begin
      bxn_counter <= off_eff;
    end else if (bxn_counter >= len_m1) begin
      // >= rather than == so a switch to the short orbit from a high count
      // wraps immediately instead of running off the end.
      bxn_counter <= '0;
    end else begin
      bxn_counter <= bxn_counter + BXN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Orbit counter: OC0 clear has priority over the BC0 increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (hard_rst || ttc_oc0) begin
      orbit_counter <= '0;
    end else if (ttc_bc0) begin
      orbit_counter <= orbit_counter + ORB_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // BC0 alignment check
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      bc0_err     <= 1'b0;
      bc0_err_cnt <= '0;
      bc0_locked  <= 1'b0;
    end else begin
      bc0_err <= bc0_misaligned;
      if (ttc_l1reset) begin
        bc0_err_cnt <= '0;
        bc0_locked  <= 1'b0;
      end else begin
        if (bc0_misaligned && (bc0_err_cnt != '1)) begin
          bc0_err_cnt <= bc0_err_cnt + ERR_W'(1);
        end
        if (ttc_bc0) begin
          bc0_locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ttc_synchro_p.sv
// Self-checking bench for ttc_synchro_p: directed scenarios followed by a
// randomized command stream, all compared against a cycle-level behavioural
// reference model written from the orbit/command rules.
module tb_ttc_synchro_p;

  localparam int BXN_W = 12;
  localparam int ORB_W = 16;
  localparam int CMD_W = 6;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int ORB_MOD = 1 << ORB_W;

  // Spec state codes
  localparam int S_STOPPED = 0;
  localparam int S_L1RST   = 1;
  localparam int S_WAIT    = 2;
  localparam int S_RUNNING = 3;

  logic             clk = 1'b0;
  logic             hard_rst = 1'b1;
  logic [CMD_W-1:0] ccb_cmd = '0;
  logic             ccb_cmd_strobe = 1'b0;
  logic [BXN_W-1:0] bxn_offset = '0;
  logic             lhc_cycle_sel = 1'b1;

  logic             ttc_bc0, ttc_l1reset, ttc_start_trigger, ttc_stop_trigger, ttc_oc0;
  logic [BXN_W-1:0] bxn_counter, bxn_before_reset;
  logic [ORB_W-1:0] orbit_counter;
  logic             l1a_cnt_reset, fmm_trig_stop, bc0_err, bc0_locked;
  logic [1:0]       fmm_state;
  logic [ERR_W-1:0] bc0_err_cnt;

  ttc_synchro_p dut (
    .clk               (clk),
    .hard_rst          (hard_rst),
    .ccb_cmd           (ccb_cmd),
    .ccb_cmd_strobe    (ccb_cmd_strobe),
    .bxn_offset        (bxn_offset),
    .lhc_cycle_sel     (lhc_cycle_sel),
    .ttc_bc0           (ttc_bc0),
    .ttc_l1reset       (ttc_l1reset),
    .ttc_start_trigger (ttc_start_trigger),
    .ttc_stop_trigger  (ttc_stop_trigger),
    .ttc_oc0           (ttc_oc0),
    .bxn_counter       (bxn_counter),
    .bxn_before_reset  (bxn_before_reset),
    .orbit_counter     (orbit_counter),
    .l1a_cnt_reset     (l1a_cnt_reset),
    .fmm_trig_stop     (fmm_trig_stop),
    .fmm_state         (fmm_state),
    .bc0_err           (bc0_err),
    .bc0_err_cnt       (bc0_err_cnt),
    .bc0_locked        (bc0_locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_bxn, m_bbr, m_orb, m_state, m_stop, m_l1a, m_err, m_cnt, m_lock;

  int codes [5] = '{1, 3, 6, 7, 8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_len();
    return lhc_cycle_sel ? 3564 : 924;
  endfunction

  function automatic int f_off();
    return (int'(bxn_offset) < f_len()) ? int'(bxn_offset) : 0;
  endfunction

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_update();
    int  len, off, exp_pos, nstate;
    bit  bc0, l1r, sta, stp, oc0;
    len = f_len();
    off = f_off();
    bc0 = ccb_cmd_strobe && (ccb_cmd == 6'd1);
    l1r = ccb_cmd_strobe && (ccb_cmd == 6'd3);
    sta = ccb_cmd_strobe && (ccb_cmd == 6'd6);
    stp = ccb_cmd_strobe && (ccb_cmd == 6'd7);
    oc0 = ccb_cmd_strobe && (ccb_cmd == 6'd8);
    if (hard_rst) begin
      m_state = S_STOPPED; m_stop = 1; m_l1a = 1;
      m_bxn = off; m_bbr = 0; m_orb = 0;
      m_err = 0; m_cnt = 0; m_lock = 0;
    end else begin
      exp_pos = (off == 0) ? len - 1 : off - 1;
      m_err = (bc0 && m_lock == 1 && m_bxn != exp_pos) ? 1 : 0;
      if (l1r) begin
        m_cnt = 0; m_lock = 0;
      end else begin
        if (m_err == 1 && m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
        if (bc0) m_lock = 1;
      end
      nstate = m_state;
      if (m_state == S_STOPPED)      nstate = l1r ? S_L1RST : (sta ? S_WAIT : S_STOPPED);
      else if (m_state == S_L1RST)   nstate = S_WAIT;
      else if (m_state == S_WAIT)    nstate = bc0 ? S_RUNNING : (l1r ? S_L1RST : (stp ? S_STOPPED : S_WAIT));
      else                           nstate = stp ? S_STOPPED : (l1r ? S_L1RST : S_RUNNING);
      if (bc0) begin
        m_bbr = m_bxn;
        m_bxn = off;
      end else if (m_state == S_L1RST) begin
        m_bxn = off;
      end else begin
        m_bxn = (m_bxn + 1 >= len) ? 0 : m_bxn + 1;
      end
      if (oc0)      m_orb = 0;
      else if (bc0) m_orb = (m_orb + 1) % ORB_MOD;
      m_state = nstate;
      m_l1a   = (nstate == S_L1RST) ? 1 : 0;
      m_stop  = (nstate != S_RUNNING) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    check("bxn_counter",      bxn_counter,      m_bxn);
    check("bxn_before_reset", bxn_before_reset, m_bbr);
    check("orbit_counter",    orbit_counter,    m_orb);
    check("l1a_cnt_reset",    l1a_cnt_reset,    m_l1a);
    check("fmm_trig_stop",    fmm_trig_stop,    m_stop);
    check("fmm_state",        fmm_state,        m_state);
    check("bc0_err",          bc0_err,          m_err);
    check("bc0_err_cnt",      bc0_err_cnt,      m_cnt);
    check("bc0_locked",       bc0_locked,       m_lock);
  endtask

  // Drive one cycle: set inputs, check decodes, clock, check registered outputs.
  task automatic step(input logic [CMD_W-1:0] cmd, input logic stb);
    ccb_cmd        = cmd;
    ccb_cmd_strobe = stb;
    #1;
    check("ttc_bc0",           ttc_bc0,           stb && cmd == 6'd1);
    check("ttc_l1reset",       ttc_l1reset,       stb && cmd == 6'd3);
    check("ttc_start_trigger", ttc_start_trigger, stb && cmd == 6'd6);
    check("ttc_stop_trigger",  ttc_stop_trigger,  stb && cmd == 6'd7);
    check("ttc_oc0",           ttc_oc0,           stb && cmd == 6'd8);
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(CMD_W'($urandom_range(0, 63)), 1'b0);
  endtask

  initial begin
    logic [CMD_W-1:0] rcmd;
    logic             rstb;
    int               r;

    // Reset held for three cycles with offset 5
    hard_rst = 1'b1; bxn_offset = 12'd5; lhc_cycle_sel = 1'b1;
    repeat (3) step(6'd0, 1'b0);
    check("rst_bxn", bxn_counter, 5);
    check("rst_trig_stop", fmm_trig_stop, 1);
    check("rst_l1a", l1a_cnt_reset, 1);
    check("rst_state", fmm_state, 0);
    hard_rst = 1'b0;
    step(6'd0, 1'b0);
    check("post_rst_bxn6", bxn_counter, 6);
    step(6'd0, 1'b0);
    check("post_rst_bxn7", bxn_counter, 7);

    // START then BC0 with offset 0
    step(6'd6, 1'b1);
    check("start_state", fmm_state, 2);
    check("start_trig_stop", fmm_trig_stop, 1);
    bxn_offset = 12'd0;
    step(6'd1, 1'b1);
    check("bc0_state", fmm_state, 3);
    check("bc0_trig_stop", fmm_trig_stop, 0);
    check("first_bc0_locked", bc0_locked, 1);
    check("first_bc0_no_err", bc0_err, 0);
    idle(3563);
    check("bxn_top", bxn_counter, 3563);
    idle(1);
    check("bxn_wrap", bxn_counter, 0);

    // Aligned BC0 one orbit later, then one 100 cycles late
    idle(3563);
    step(6'd1, 1'b1);
    check("aligned_no_err", bc0_err, 0);
    check("aligned_cnt", bc0_err_cnt, 0);
    idle(99);
    step(6'd1, 1'b1);
    check("late_err", bc0_err, 1);
    check("late_cnt", bc0_err_cnt, 1);
    check("late_bbr", bxn_before_reset, 99);
    idle(1);
    check("err_pulse_end", bc0_err, 0);

    // L1Reset while running, then STOP
    step(6'd3, 1'b1);
    check("l1r_state", fmm_state, 1);
    check("l1r_pulse", l1a_cnt_reset, 1);
    check("l1r_trig_stop", fmm_trig_stop, 1);
    check("l1r_cnt_clr", bc0_err_cnt, 0);
    step(6'd0, 1'b0);
    check("l1r_to_wait", fmm_state, 2);
    check("l1r_pulse_end", l1a_cnt_reset, 0);
    step(6'd7, 1'b1);
    check("stop_state", fmm_state, 0);

    // Orbit counter
    step(6'd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(6'd1, 1'b1);
      idle(10);
    end
    check("orbit_5", orbit_counter, 5);
    step(6'd8, 1'b1);
    check("oc0_clear", orbit_counter, 0);

    // Mid-orbit switch to the short orbit
    step(6'd1, 1'b1);
    idle(2000);
    check("bxn_2000", bxn_counter, 2000);
    lhc_cycle_sel = 1'b0;
    step(6'd0, 1'b0);
    check("short_switch_wrap", bxn_counter, 0);
    lhc_cycle_sel = 1'b1;

    // Offset beyond the orbit length loads 0
    bxn_offset = 12'd4000;
    step(6'd1, 1'b1);
    check("big_offset", bxn_counter, 0);
    bxn_offset = 12'd0;

    // Strobe low with the BC0 code: no decode, no count
    step(6'd1, 1'b0);
    check("nostrobe_orbit", orbit_counter, 2);

    // Error counter saturation with back-to-back misaligned BC0s
    for (int i = 0; i < 260; i++) step(6'd1, 1'b1);
    check("err_cnt_sat", bc0_err_cnt, ERR_MAX);

    // Reset together with a BC0 strobe
    hard_rst = 1'b1;
    step(6'd1, 1'b1);
    check("rst_bc0_orbit", orbit_counter, 0);
    check("rst_bc0_locked", bc0_locked, 0);
    check("rst_bc0_cnt", bc0_err_cnt, 0);
    hard_rst = 1'b0;
    step(6'd0, 1'b0);

    // Randomized command stream
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) lhc_cycle_sel = ~lhc_cycle_sel;
      if ($urandom_range(0, 49) == 0)  bxn_offset = BXN_W'($urandom_range(0, 4095));
      hard_rst = ($urandom_range(0, 499) == 0);
      r = $urandom_range(0, 15);
      if (r < 5) rcmd = CMD_W'(codes[r]);
      else       rcmd = CMD_W'($urandom_range(0, 63));
      rstb = ($urandom_range(0, 5) == 0);
      step(rcmd, rstb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
